ex_result_stage: RTL and testbench
==================================

EX_RESULT_STAGE -- requirements
Module: ex_result_stage

Interface
REQ-001 Parameter: WIDTH, 32, ALU result width in bits (number of ALU bit-slices).
REQ-002 Parameter: RD_W, 5, destination-register index width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  upstream ALU word present this cycle.
REQ-006 in_ready  output  1  stage can accept a word this cycle.
REQ-007 in_result  input  WIDTH  concatenated sum outputs of the ALU bit-slices.
REQ-008 in_cout  input  1  carry-out of MSB slice.
REQ-009 in_cin_msb  input  1  carry-in of MSB slice.
REQ-010 in_sel  input  2  slice select (00 AND, 01 OR, 10 ADD/SUB, 11 SLT).
REQ-011 in_rd  input  RD_W  destination register tag.
REQ-012 flush  input  1  discard all held and incoming words.
REQ-013 out_valid  output  1  out_* fields valid.
REQ-014 out_ready  input  1  downstream (MEM stage) accepts.
REQ-015 out_result / out_zero / out_ovf / out_rd  output  WIDTH / 1 / 1 / RD_W  registered result, zero flag, signed overflow, tag.

Function
REQ-016 Two-entry skid buffer: MAIN (drives out_*) and SKID; each entry holds result, zero, ovf, rd, valid bit.
REQ-017 in_ready SHALL equal NOT SKID.valid (registered, no combinational path from out_ready).
REQ-018 Accept when in_valid & in_ready; drain when out_valid & out_ready.
REQ-019 zero SHALL be computed at accept as (in_result == 0), independent of in_sel.
REQ-020 ovf SHALL be computed at accept as in_cout XOR in_cin_msb when in_sel==2'b10, else 0.
REQ-021 Latency: word accepted in cycle N appears on out_* in cycle N+1 when MAIN empty or draining.
REQ-022 MAIN load priority when MAIN empty or draining: SKID if SKID.valid, else accepted input; SKID cleared when it moves to MAIN.
REQ-023 Accept while MAIN full and not draining SHALL write SKID; accept impossible while SKID full.
REQ-024 Simultaneous accept and drain with SKID empty: input goes straight to MAIN, SKID stays empty.
REQ-025 Order SHALL be preserved; no word dropped or duplicated except by flush.
REQ-026 out_* SHALL remain stable while out_valid & !out_ready.
REQ-027 flush: both valid bits cleared on that edge; input offered in the flush cycle is dropped; in_ready = 1 next cycle.
REQ-028 flush has priority over accept and drain in the same cycle.

Reset
REQ-029 rst asserted (any time, mid-transfer included): MAIN.valid=SKID.valid=0 immediately; out_valid=0, out_result=0, out_zero=0, out_ovf=0, out_rd=0, in_ready=1.
REQ-030 First accept possible on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro EX_RESULT_OVF_TRAP_EN: when defined, add outputs ovf_trap (1) and input ovf_clr (1); ovf_trap is a sticky flag set on the edge MAIN drains a word with ovf=1, cleared by ovf_clr (set wins if both), reset 0; a drained word with ovf=1 SHALL present out_rd=0 (writeback suppressed).
REQ-032 Without EX_RESULT_OVF_TRAP_EN: ports ovf_trap/ovf_clr absent; out_rd always the stored tag; out_ovf still reported.

Verification
REQ-033 Single ADD: in_result=0x00000000, sel=10, cout=1, cin_msb=1, rd=3, out_ready=1 -> next cycle out_valid=1, out_zero=1, out_ovf=0, out_rd=3.
REQ-034 Overflow: 0x7FFFFFFF+1, sel=10, cout=0, cin_msb=1 -> out_ovf=1; with macro, out_rd=0 and ovf_trap=1 after drain; ovf_clr -> ovf_trap=0.
REQ-035 Backpressure: out_ready=0, push words A,B -> in_ready=0 after B; out_ready=1 -> A then B on consecutive cycles, in_ready=1 after A drains.
REQ-036 Streaming: in_valid=out_ready=1 for 8 cycles, values 1..8 -> outputs 1..8 back-to-back, SKID never used.
REQ-037 Flush with A in MAIN, B in SKID, C offered -> next cycle out_valid=0, in_ready=1; A, B, C never appear.
REQ-038 rst asserted asynchronously mid-backpressure -> out_valid=0 and out_*=0 before next clock edge.

Source files
------------

// File: rtl/ex_result_stage.sv
// EX result stage: two-entry skid buffer (MAIN drives out_*, SKID catches one word under backpressure).
// Latency 1 cycle; in_ready is !SKID.valid (registered); optional EX_RESULT_OVF_TRAP_EN adds sticky ovf_trap.
module ex_result_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_cout,
  input  logic             in_cin_msb,
  input  logic [1:0]       in_sel,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [RD_W-1:0]  out_rd
`ifdef EX_RESULT_OVF_TRAP_EN
  ,
  output logic             ovf_trap,
  input  logic             ovf_clr
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic [RD_W-1:0]  rd;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, in_ent;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic   accept, drain;

  // Flags are formed once at accept so the held word never depends on live inputs.
  always_comb begin
    in_ent        = '0;
    in_ent.result = in_result;
    in_ent.zero   = (in_result == '0);
    in_ent.ovf    = (in_sel == 2'b10) & (in_cout ^ in_cin_msb);
    in_ent.rd     = in_rd;
  end

  assign in_ready = !skid_vld_q;
  assign accept   = in_valid & in_ready & !flush;
  assign drain    = main_vld_q & out_ready & !flush;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || drain) begin
      // SKID holds the older word, so it refills MAIN first; accept cannot coincide with SKID full.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = in_ent;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid  = main_vld_q;
  assign out_result = main_q.result;
  assign out_zero   = main_q.zero;
  assign out_ovf    = main_q.ovf;

`ifdef EX_RESULT_OVF_TRAP_EN
  logic trap_q, trap_d;

  always_comb begin
    trap_d = trap_q;
    if (ovf_clr)
      trap_d = 1'b0;
    if (drain && main_q.ovf)
      trap_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      trap_q <= 1'b0;
    else
      trap_q <= trap_d;
  end

  assign ovf_trap = trap_q;
  // An overflowing word must not write back, so its tag is squashed to r0.
  assign out_rd   = main_q.ovf ? '0 : main_q.rd;
`else
  assign out_rd   = main_q.rd;
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: reset, flags, backpressure, streaming, flush, async reset.
module tb_ex_result_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_cout;
  logic        in_cin_msb;
  logic [1:0]  in_sel;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  logic [4:0]  out_rd;
`ifdef EX_RESULT_OVF_TRAP_EN
  logic        ovf_trap;
  logic        ovf_clr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_result_stage #(.WIDTH(32), .RD_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_cout    (in_cout),
    .in_cin_msb (in_cin_msb),
    .in_sel     (in_sel),
    .in_rd      (in_rd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .out_rd     (out_rd)
`ifdef EX_RESULT_OVF_TRAP_EN
    ,
    .ovf_trap   (ovf_trap),
    .ovf_clr    (ovf_clr)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic co,
                       input logic ci, input logic [1:0] sel, input logic [4:0] rd);
    in_valid   = v;
    in_result  = res;
    in_cout    = co;
    in_cin_msb = ci;
    in_sel     = sel;
    in_rd      = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty_zero(input string name);
    chk({name, "_valid"},  32'(out_valid),  0);
    chk({name, "_result"}, out_result,      0);
    chk({name, "_zero"},   32'(out_zero),   0);
    chk({name, "_ovf"},    32'(out_ovf),    0);
    chk({name, "_rd"},     32'(out_rd),     0);
    chk({name, "_ready"},  32'(in_ready),   1);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
`ifdef EX_RESULT_OVF_TRAP_EN
    ovf_clr = 1'b0;
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 5'd0);
    #3;
    chk_empty_zero("reset");
    #9;
    rst = 1'b0;

    // Single ADD with zero result, cout==cin so no overflow
    drive(1'b1, 32'h0, 1'b1, 1'b1, 2'b10, 5'd3);
    out_ready = 1'b1;
    tick();
    chk("add_valid", 32'(out_valid), 1);
    chk("add_zero",  32'(out_zero),  1);
    chk("add_ovf",   32'(out_ovf),   0);
    chk("add_rd",    32'(out_rd),    3);
    in_valid = 1'b0;
    tick();
    chk("add_drained", 32'(out_valid), 0);

    // Overflow: 0x7FFFFFFF + 1
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 2'b10, 5'd5);
    tick();
    chk("ovf_valid",  32'(out_valid), 1);
    chk("ovf_ovf",    32'(out_ovf),   1);
    chk("ovf_zero",   32'(out_zero),  0);
    chk("ovf_result", out_result,     32'h8000_0000);
`ifdef EX_RESULT_OVF_TRAP_EN
    chk("ovf_rd", 32'(out_rd), 0);
    chk("trap_before_drain", 32'(ovf_trap), 0);
`else
    chk("ovf_rd", 32'(out_rd), 5);
`endif
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ovf_drained", 32'(out_valid), 0);
`ifdef EX_RESULT_OVF_TRAP_EN
    chk("trap_set", 32'(ovf_trap), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("trap_clr", 32'(ovf_trap), 0);
`endif

    // Carry mismatch on an AND op must not flag overflow
    drive(1'b1, 32'h5, 1'b1, 1'b0, 2'b00, 5'd7);
    tick();
    chk("and_ovf",  32'(out_ovf),  0);
    chk("and_zero", 32'(out_zero), 0);
    chk("and_rd",   32'(out_rd),   7);
    in_valid = 1'b0;
    tick();

    // Backpressure: A then B fill MAIN and SKID
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b0, 1'b0, 2'b01, 5'd1);
    tick();
    chk("bp_a_valid", 32'(out_valid), 1);
    chk("bp_a_ready", 32'(in_ready),  1);
    drive(1'b1, 32'hB, 1'b0, 1'b0, 2'b01, 5'd2);
    tick();
    chk("bp_b_ready",  32'(in_ready), 0);
    chk("bp_b_main",   out_result,    32'hA);
    in_valid = 1'b0;
    tick();
    chk("bp_stable_result", out_result,  32'hA);
    chk("bp_stable_rd",     32'(out_rd), 1);
    out_ready = 1'b1;
    tick();
    chk("bp_second",       out_result,      32'hB);
    chk("bp_second_rd",    32'(out_rd),     2);
    chk("bp_second_valid", 32'(out_valid),  1);
    chk("bp_ready_again",  32'(in_ready),   1);
    tick();
    chk("bp_empty", 32'(out_valid), 0);

    // Streaming 1..8 back-to-back, SKID never used
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 2'b01, 5'(i));
      tick();
      chk("stream_result", out_result,     32'(i));
      chk("stream_valid",  32'(out_valid), 1);
      chk("stream_ready",  32'(in_ready),  1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end", 32'(out_valid), 0);

    // Flush with A in MAIN, B in SKID, C offered
    out_ready = 1'b0;
    drive(1'b1, 32'h1A, 1'b0, 1'b0, 2'b01, 5'd10);
    tick();
    drive(1'b1, 32'h1B, 1'b0, 1'b0, 2'b01, 5'd11);
    tick();
    chk("fl_full", 32'(in_ready), 0);
    drive(1'b1, 32'h1C, 1'b0, 1'b0, 2'b01, 5'd12);
    flush = 1'b1;
    tick();
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_ready", 32'(in_ready),  1);
    // Flush also wins over an accept the stage could otherwise take
    drive(1'b1, 32'h1D, 1'b0, 1'b0, 2'b01, 5'd13);
    tick();
    chk("fl_accept_dropped", 32'(out_valid), 0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_nothing_after", 32'(out_valid), 0);

    // Async reset mid-backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD, 1'b1, 1'b0, 2'b10, 5'd9);
    tick();
    drive(1'b1, 32'hBEEF, 1'b0, 1'b0, 2'b01, 5'd8);
    tick();
    chk("ar_pre_valid", 32'(out_valid), 1);
    chk("ar_pre_ready", 32'(in_ready),  0);
    #2;
    rst = 1'b1;
    #1;
    chk_empty_zero("async_rst");
    #2;
    rst = 1'b0;
    drive(1'b1, 32'h42, 1'b0, 1'b0, 2'b01, 5'd4);
    out_ready = 1'b1;
    tick();
    chk("post_rst_valid",  32'(out_valid), 1);
    chk("post_rst_result", out_result,     32'h42);
    chk("post_rst_rd",     32'(out_rd),    4);
    in_valid = 1'b0;
    tick();
    chk("post_rst_drain", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
